// File: rtl/comparator_pkg.sv
// -----------------------------------------------------------------------------
// comparator_pkg
//
// Shared definitions for the registered magnitude comparator.
//
// Contents:
//   CMP_WIDTH     default operand width of comparator_4bit
//   cmp_result_t  packed 3-bit result {gt, eq, lt}
//   CMP_*         the four legal result encodings
//   cmp_is_legal  true when a result is one-hot or the "no result yet" pattern
// -----------------------------------------------------------------------------
package comparator_pkg;

  localparam int CMP_WIDTH = 4;

  // Bit order matches the flag naming: MSB is "greater", LSB is "less".
  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_result_t;

  // CMP_NONE is the reset pattern and means "no comparison registered yet".
  localparam cmp_result_t CMP_NONE = 3'b000;
  localparam cmp_result_t CMP_GT   = 3'b100;
  localparam cmp_result_t CMP_EQ   = 3'b010;
  localparam cmp_result_t CMP_LT   = 3'b001;

  // A result is legal when it is exactly one of the four encodings above.
  function automatic logic cmp_is_legal(input cmp_result_t r);
    logic legal;
    legal = (r == CMP_NONE) || (r == CMP_GT) ||
            (r == CMP_EQ)   || (r == CMP_LT);
    return legal;
  endfunction

endpackage : comparator_pkg

// File: rtl/comparator_slice.sv
// -----------------------------------------------------------------------------
// comparator_slice
//
// One bit of the MSB-to-LSB magnitude comparison cascade. A decision that was
// already made by a more-significant bit is passed through untouched; only when
// no decision exists yet does this bit compare a_i against b_i.
//
// Ports:
//   a_i     operand A bit at this position
//   b_i     operand B bit at this position
//   gt_in   "A > B" already decided by a more-significant bit
//   lt_in   "A < B" already decided by a more-significant bit
//   gt_out  "A > B" decided at or above this bit
//   lt_out  "A < B" decided at or above this bit
//
// gt_in and lt_in are never both 1: the cascade is seeded with 0/0 and each
// cell sets at most one output, and only when neither input is set.
// -----------------------------------------------------------------------------
module comparator_slice (
  input  logic a_i,
  input  logic b_i,
  input  logic gt_in,
  input  logic lt_in,
  output logic gt_out,
  output logic lt_out
);

  logic decided;

  assign decided = gt_in | lt_in;

  always_comb begin
    gt_out = gt_in;
    lt_out = lt_in;
    if (!decided) begin
      // First differing bit decides; equal bits leave the cascade undecided.
      gt_out = a_i & ~b_i;
      lt_out = ~a_i & b_i;
    end
  end

endmodule : comparator_slice

// File: rtl/comparator_4bit.sv
// -----------------------------------------------------------------------------
// comparator_4bit
//
// Registered unsigned magnitude comparator. Every rising clk edge samples A and
// B and registers three mutually exclusive flags. There is no valid/ready
// handshake: a new comparison is taken on every edge, and the flags always
// describe the operands sampled at the most recent non-reset edge.
//
// Parameters:
//   WIDTH  operand width in bits (default CMP_WIDTH = 4)
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high; forces all flags to 0
//   A     operand A, unsigned
//   B     operand B, unsigned
//   AeqB  registered flag, A == B
//   AgtB  registered flag, A >  B
//   AltB  registered flag, A <  B
//
// Outside reset exactly one flag is set. All-zero appears only while rst is
// high at an edge and means "no result yet".
// -----------------------------------------------------------------------------
module comparator_4bit
  import comparator_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             AeqB,
  output logic             AgtB,
  output logic             AltB
);

  // Cascade nets: index WIDTH is the seed above the MSB, index 0 is the final
  // decision after the LSB slice.
  logic [WIDTH:0] gt_chain;
  logic [WIDTH:0] lt_chain;

  assign gt_chain[WIDTH] = 1'b0;
  assign lt_chain[WIDTH] = 1'b0;

  // Slice i receives the decision from bit i+1, so the MSB slice sees the seed
  // and the LSB slice produces the final answer.
  for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_slice
    comparator_slice u_slice (
      .a_i    (A[i]),
      .b_i    (B[i]),
      .gt_in  (gt_chain[i+1]),
      .lt_in  (lt_chain[i+1]),
      .gt_out (gt_chain[i]),
      .lt_out (lt_chain[i])
    );
  end

  cmp_result_t result_d;
  cmp_result_t result_q;

  always_comb begin
    result_d    = CMP_NONE;
    result_d.gt = gt_chain[0];
    result_d.lt = lt_chain[0];
    // No differing bit anywhere means the operands are equal.
    result_d.eq = ~gt_chain[0] & ~lt_chain[0];
  end

  // Reset dominates: a result computed in the cycle rst rises is dropped, and
  // any X left over from unsupported operand values is flushed to CMP_NONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= CMP_NONE;
    end else begin
      result_q <= result_d;
    end
  end

  assign AgtB = result_q.gt;
  assign AeqB = result_q.eq;
  assign AltB = result_q.lt;

  // The registered result is always one-hot or the reset pattern.
  a_result_legal : assert property (@(posedge clk) cmp_is_legal(result_q));

endmodule : comparator_4bit

// File: tb/tb_comparator_4bit.sv
// -----------------------------------------------------------------------------
// tb_comparator_4bit
//
// Directed and random checks of comparator_4bit. Inputs are driven on the
// falling edge, sampled by the DUT on the following rising edge, and the flags
// are observed on the next falling edge.
// -----------------------------------------------------------------------------
module tb_comparator_4bit;

  localparam int W = 4;

  // ---------------------------------------------------------------- clock/reset
  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         aeqb;
  logic         agtb;
  logic         altb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  comparator_4bit #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (a),
    .B    (b),
    .AeqB (aeqb),
    .AgtB (agtb),
    .AltB (altb)
  );

  // ----------------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];
  bit covered [16][16];

  // Reference: flags {gt, eq, lt} straight from integer comparison.
  function automatic logic [2:0] ref_flags(input int av, input int bv, input logic r);
    logic [2:0] f;
    if (r)            f = 3'b000;
    else if (av > bv) f = 3'b100;
    else if (av < bv) f = 3'b001;
    else              f = 3'b010;
    return f;
  endfunction

  task automatic check_flags(input string tag);
    logic [2:0] got;
    logic [2:0] exp;
    got = {agtb, aeqb, altb};
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: expected queue empty, observed %b", tag, got);
    end else begin
      exp = exp_q.pop_front();
      checks++;
      assert (got === exp) else begin
        errors++;
        $error("FAIL %s: observed gt/eq/lt=%b expected %b (A=%0d B=%0d)", tag, got, exp, a, b);
      end
    end
  endtask

  // --------------------------------------------------------------- driver tasks
  // Called on a falling edge; returns on the next falling edge after checking.
  task automatic step(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic r, input string tag);
    logic [2:0] got;
    a   = av;
    b   = bv;
    rst = r;
    exp_q.push_back(ref_flags(int'(av), int'(bv), r));
    if (!r) covered[av][bv] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_flags(tag);
    if (!r) begin
      got = {agtb, aeqb, altb};
      checks++;
      assert ($onehot(got)) else begin
        errors++;
        $error("FAIL %s_onehot: observed gt/eq/lt=%b expected exactly one bit set", tag, got);
      end
    end
  endtask

  // Watchdog: the run is a fixed sequence, so this only trips if time stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------------- stimulus
  initial begin
    int cov_count;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst = 1'b1;
    a   = '0;
    b   = '0;
    @(negedge clk);

    // Reset held three cycles with operands that would otherwise give GT.
    for (int i = 0; i < 3; i++) step(4'b1010, 4'b0011, 1'b1, "reset_hold");
    step(4'b1010, 4'b0011, 1'b0, "reset_release");

    // Equality and extremes.
    step(4'd0,  4'd0,  1'b0, "eq_zero");
    step(4'd15, 4'd15, 1'b0, "eq_max");
    step(4'd15, 4'd0,  1'b0, "gt_extreme");
    step(4'd0,  4'd15, 1'b0, "lt_extreme");

    // MSB outweighs all lower bits.
    step(4'b1000, 4'b0111, 1'b0, "msb_gt");
    step(4'b0111, 4'b1000, 1'b0, "msb_lt");

    // Only the LSB differs.
    step(4'b0110, 4'b0111, 1'b0, "lsb_lt");
    step(4'b0111, 4'b0110, 1'b0, "lsb_gt");

    // Back-to-back operands, then the same with reset during the middle cycle.
    step(4'd3, 4'd5, 1'b0, "pipe_3_5");
    step(4'd5, 4'd3, 1'b0, "pipe_5_3");
    step(4'd9, 4'd9, 1'b0, "pipe_9_9");
    step(4'd3, 4'd5, 1'b0, "midrst_3_5");
    step(4'd5, 4'd3, 1'b1, "midrst_5_3");
    step(4'd9, 4'd9, 1'b0, "midrst_9_9");

    // Random operands, one comparison per cycle.
    for (int i = 0; i < 2000; i++) begin
      ra = W'($urandom_range(0, 15));
      rb = W'($urandom_range(0, 15));
      step(ra, rb, 1'b0, "random");
    end

    // Close any gaps in pair coverage left by the random run.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        if (!covered[i][j]) step(W'(i), W'(j), 1'b0, "sweep");
      end
    end

    cov_count = 0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        if (covered[i][j]) cov_count++;
    checks++;
    assert (cov_count == 256) else begin
      errors++;
      $error("FAIL pair_coverage: observed %0d pairs expected 256", cov_count);
    end

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL queue_drain: observed %0d leftover expectations expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_comparator_4bit
